// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART monitor/boot loader that owns RAM and UART while the CPU is idle
//
// Executes host commands received over the UART:
//   'L' ah al n d0..dn-1 : write n bytes to RAM starting at {ah,al}, reply '.'
//   'D' ah al n          : read n bytes from RAM starting at {ah,al}, send each one
//   'G' ah al            : start the CPU at {ah,al}, reply '!' once the CPU halts
//   anything else        : reply '?'
// A length byte of 0 means 256. Addresses keep the low addr_width bits of {ah,al}
// and wrap at the top of memory.
//
// Ports:
//   clk, rst           clock (rising edge) and asynchronous active-low reset
//   received, rx_byte  one-cycle receive strobe and the received byte
//   is_transmitting    UART transmitter busy flag
//   tx_byte, transmit  byte to send and its one-cycle strobe
//   raddr, dread       RAM read address and read data (synchronous RAM)
//   waddr, dwrite      RAM write address and write data
//   write_en           one-cycle RAM write strobe
//   mem_sel            1 = loader owns RAM/UART, 0 = CPU owns them
//   cpu_run            one-cycle CPU start pulse
//   startaddr          CPU start address, held stable
//   cpu_halted         one-cycle pulse from the CPU when it executes HLT

module uart_loader #(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  received,
   input  logic [7:0]            rx_byte,
   input  logic                  is_transmitting,
   output logic [7:0]            tx_byte,
   output logic                  transmit,
   output logic [addr_width-1:0] raddr,
   output logic [addr_width-1:0] waddr,
   output logic [7:0]            dwrite,
   output logic                  write_en,
   input  logic [7:0]            dread,
   output logic                  mem_sel,
   output logic                  cpu_run,
   output logic [addr_width-1:0] startaddr,
   input  logic                  cpu_halted
);

   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_DUMP  = 8'h44;
   localparam logic [7:0] CMD_GO    = 8'h47;
   localparam logic [7:0] RSP_ACK   = 8'h2E;
   localparam logic [7:0] RSP_HALT  = 8'h21;
   localparam logic [7:0] RSP_ERROR = 8'h3F;

   localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE,
      GET_AH,
      GET_AL,
      GET_N,
      LOAD_DATA,
      LOAD_WR,
      DUMP_RD,
      DUMP_WAIT,
      DUMP_LATCH,
      TX_WAIT,
      TX_GUARD,
      GO,
      RUN
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cmd_q, cmd_d;
   logic [7:0]            ah_q, ah_d;
   logic [addr_width-1:0] addr_q, addr_d;
   logic [8:0]            count_q, count_d;
   logic [7:0]            txd_q, txd_d;
   // Destination after TX_GUARD: 1 = DUMP_RD (more dump bytes pending), 0 = IDLE.
   logic                  ret_dump_q, ret_dump_d;

   logic [7:0]            tx_byte_q, tx_byte_d;
   logic                  transmit_q, transmit_d;
   logic [addr_width-1:0] raddr_q, raddr_d;
   logic [addr_width-1:0] waddr_q, waddr_d;
   logic [7:0]            dwrite_q, dwrite_d;
   logic                  write_en_q, write_en_d;
   logic                  mem_sel_q, mem_sel_d;
   logic                  cpu_run_q, cpu_run_d;
   logic [addr_width-1:0] startaddr_q, startaddr_d;

   logic [addr_width-1:0] addr_inc;
   logic                  last_byte;

   assign addr_inc  = addr_q + ADDR_ONE;
   assign last_byte = (count_q == 9'd1);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      ah_d        = ah_q;
      addr_d      = addr_q;
      count_d     = count_q;
      txd_d       = txd_q;
      ret_dump_d  = ret_dump_q;
      tx_byte_d   = tx_byte_q;
      transmit_d  = 1'b0;
      raddr_d     = raddr_q;
      waddr_d     = waddr_q;
      dwrite_d    = dwrite_q;
      write_en_d  = 1'b0;
      mem_sel_d   = mem_sel_q;
      cpu_run_d   = 1'b0;
      startaddr_d = startaddr_q;

      case (state_q)
         IDLE: begin
            if (received) begin
               if (rx_byte == CMD_LOAD || rx_byte == CMD_DUMP || rx_byte == CMD_GO) begin
                  cmd_d   = rx_byte;
                  state_d = GET_AH;
               end else begin
                  txd_d      = RSP_ERROR;
                  ret_dump_d = 1'b0;
                  state_d    = TX_WAIT;
               end
            end
         end
         GET_AH: begin
            if (received) begin
               ah_d    = rx_byte;
               state_d = GET_AL;
            end
         end
         GET_AL: begin
            if (received) begin
               // High address bits beyond the RAM size are dropped.
               addr_d  = addr_width'({ah_q, rx_byte});
               state_d = (cmd_q == CMD_GO) ? GO : GET_N;
            end
         end
         GET_N: begin
            if (received) begin
               count_d = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
               state_d = (cmd_q == CMD_LOAD) ? LOAD_DATA : DUMP_RD;
            end
         end
         LOAD_DATA: begin
            // Issue the write straight from the strobe so it lands the next cycle.
            if (received) begin
               waddr_d    = addr_q;
               dwrite_d   = rx_byte;
               write_en_d = 1'b1;
               state_d    = LOAD_WR;
            end
         end
         LOAD_WR: begin
            // write_en is high this cycle; advance past the byte just written.
            addr_d  = addr_inc;
            count_d = count_q - 9'd1;
            if (last_byte) begin
               txd_d      = RSP_ACK;
               ret_dump_d = 1'b0;
               state_d    = TX_WAIT;
            end else if (received) begin
               // A byte arriving alongside the write is captured, not lost.
               waddr_d    = addr_inc;
               dwrite_d   = rx_byte;
               write_en_d = 1'b1;
            end else begin
               state_d = LOAD_DATA;
            end
         end
         DUMP_RD: begin
            raddr_d = addr_q;
            state_d = DUMP_WAIT;
         end
         DUMP_WAIT: begin
            // The synchronous RAM returns data one cycle after raddr settles.
            state_d = DUMP_LATCH;
         end
         DUMP_LATCH: begin
            txd_d      = dread;
            addr_d     = addr_inc;
            count_d    = count_q - 9'd1;
            ret_dump_d = !last_byte;
            state_d    = TX_WAIT;
         end
         TX_WAIT: begin
            if (!is_transmitting) begin
               tx_byte_d  = txd_q;
               transmit_d = 1'b1;
               state_d    = TX_GUARD;
            end
         end
         TX_GUARD: begin
            // Gives the UART a cycle to raise its busy flag before it is sampled again.
            state_d = ret_dump_q ? DUMP_RD : IDLE;
         end
         GO: begin
            startaddr_d = addr_q;
            mem_sel_d   = 1'b0;
            cpu_run_d   = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            // The CPU owns the UART here, so received strobes are not ours.
            if (cpu_halted) begin
               mem_sel_d  = 1'b1;
               txd_d      = RSP_HALT;
               ret_dump_d = 1'b0;
               state_d    = TX_WAIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cmd_q       <= 8'd0;
         ah_q        <= 8'd0;
         addr_q      <= '0;
         count_q     <= 9'd0;
         txd_q       <= 8'd0;
         ret_dump_q  <= 1'b0;
         tx_byte_q   <= 8'd0;
         transmit_q  <= 1'b0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         dwrite_q    <= 8'd0;
         write_en_q  <= 1'b0;
         mem_sel_q   <= 1'b1;
         cpu_run_q   <= 1'b0;
         startaddr_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         ah_q        <= ah_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         txd_q       <= txd_d;
         ret_dump_q  <= ret_dump_d;
         tx_byte_q   <= tx_byte_d;
         transmit_q  <= transmit_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         dwrite_q    <= dwrite_d;
         write_en_q  <= write_en_d;
         mem_sel_q   <= mem_sel_d;
         cpu_run_q   <= cpu_run_d;
         startaddr_q <= startaddr_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign transmit  = transmit_q;
   assign raddr     = raddr_q;
   assign waddr     = waddr_q;
   assign dwrite    = dwrite_q;
   assign write_en  = write_en_q;
   assign mem_sel   = mem_sel_q;
   assign cpu_run   = cpu_run_q;
   assign startaddr = startaddr_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader
//
// Holds a synchronous RAM, a UART transmitter busy model and a command-level
// reference model (expected writes, transmitted bytes and CPU starts).
// Ports: none (top-level bench).

module tb_uart_loader;

   localparam int AW   = 9;
   localparam int MASK = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          received;
   logic [7:0]    rx_byte;
   logic          is_transmitting;
   logic [7:0]    tx_byte;
   logic          transmit;
   logic [AW-1:0] raddr;
   logic [AW-1:0] waddr;
   logic [7:0]    dwrite;
   logic          write_en;
   logic [7:0]    dread;
   logic          mem_sel;
   logic          cpu_run;
   logic [AW-1:0] startaddr;
   logic          cpu_halted;

   always #5 clk = ~clk;

   uart_loader #(.addr_width(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .received        (received),
      .rx_byte         (rx_byte),
      .is_transmitting (is_transmitting),
      .tx_byte         (tx_byte),
      .transmit        (transmit),
      .raddr           (raddr),
      .waddr           (waddr),
      .dwrite          (dwrite),
      .write_en        (write_en),
      .dread           (dread),
      .mem_sel         (mem_sel),
      .cpu_run         (cpu_run),
      .startaddr       (startaddr),
      .cpu_halted      (cpu_halted)
   );

   // Synchronous RAM plus a bench-side preload port.
   logic [7:0]    ram [0:MASK];
   logic          pre_we;
   logic [AW-1:0] pre_addr;
   logic [7:0]    pre_data;

   always @(posedge clk) begin
      if (write_en) ram[waddr] <= dwrite;
      if (pre_we)   ram[pre_addr] <= pre_data;
      dread <= ram[raddr];
   end

   // UART transmitter: busy for 7 cycles after each transmit strobe.
   int busy_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst)          busy_cnt <= 0;
      else if (transmit) busy_cnt <= 7;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign is_transmitting = (busy_cnt != 0);

   // Reference model state.
   logic [7:0] ref_mem [0:MASK];
   int exp_wa[$];
   int exp_wd[$];
   int exp_tx[$];
   int exp_run[$];
   int tx_log[$];
   int payload[$];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare process: every strobe the DUT raises must match the model.
   logic prev_tx  = 1'b0;
   logic prev_run = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         if (write_en) begin
            if (exp_wa.size() == 0) check("unexpected_write_en", int'(write_en), 0);
            else begin
               check("waddr", int'(waddr), exp_wa.pop_front());
               check("dwrite", int'(dwrite), exp_wd.pop_front());
            end
         end
         if (transmit) begin
            tx_log.push_back(int'(tx_byte));
            check("tx_while_busy", int'(is_transmitting), 0);
            check("transmit_width", int'(prev_tx), 0);
            if (exp_tx.size() == 0) check("unexpected_transmit", int'(transmit), 0);
            else check("tx_byte", int'(tx_byte), exp_tx.pop_front());
         end
         if (cpu_run) begin
            check("cpu_run_width", int'(prev_run), 0);
            check("mem_sel_at_run", int'(mem_sel), 0);
            if (exp_run.size() == 0) check("unexpected_cpu_run", int'(cpu_run), 0);
            else check("startaddr", int'(startaddr), exp_run.pop_front());
         end
         prev_tx  = transmit;
         prev_run = cpu_run;
      end else begin
         prev_tx  = 1'b0;
         prev_run = 1'b0;
      end
   end

   task automatic send_byte(input int b, input int g);
      received = 1'b1;
      rx_byte  = 8'(b);
      @(negedge clk);
      received = 1'b0;
      repeat (g) @(negedge clk);
   endtask

   task automatic wait_quiet(input string name, input int limit);
      int n = 0;
      while ((exp_wa.size() != 0 || exp_tx.size() != 0 || exp_run.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(n < limit), 1);
      exp_wa.delete();
      exp_wd.delete();
      exp_tx.delete();
      exp_run.delete();
      repeat (12) @(negedge clk);
   endtask

   // Load command using payload[]; n is the length byte as sent (0 = 256).
   task automatic host_load(input int a, input int n, input int dgap);
      int cnt = (n == 0) ? 256 : n;
      for (int i = 0; i < cnt; i++) begin
         exp_wa.push_back((a + i) & MASK);
         exp_wd.push_back(payload[i]);
         ref_mem[(a + i) & MASK] = 8'(payload[i]);
      end
      exp_tx.push_back(8'h2E);
      send_byte(8'h4C, 3);
      send_byte((a >> 8) & 255, 3);
      send_byte(a & 255, 3);
      send_byte(n, 3);
      for (int i = 0; i < cnt; i++) send_byte(payload[i], dgap);
   endtask

   task automatic host_dump(input int a, input int n);
      int cnt = (n == 0) ? 256 : n;
      for (int i = 0; i < cnt; i++) exp_tx.push_back(int'(ref_mem[(a + i) & MASK]));
      send_byte(8'h44, 3);
      send_byte((a >> 8) & 255, 3);
      send_byte(a & 255, 3);
      send_byte(n, 3);
   endtask

   task automatic pulse_halted();
      cpu_halted = 1'b1;
      @(negedge clk);
      cpu_halted = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_sel"},   int'(mem_sel), 1);
      check({tag, "_transmit"},  int'(transmit), 0);
      check({tag, "_write_en"},  int'(write_en), 0);
      check({tag, "_cpu_run"},   int'(cpu_run), 0);
      check({tag, "_tx_byte"},   int'(tx_byte), 0);
      check({tag, "_raddr"},     int'(raddr), 0);
      check({tag, "_waddr"},     int'(waddr), 0);
      check({tag, "_dwrite"},    int'(dwrite), 0);
      check({tag, "_startaddr"}, int'(startaddr), 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b0;
      received   = 1'b0;
      rx_byte    = 8'd0;
      cpu_halted = 1'b0;
      pre_we     = 1'b0;
      pre_addr   = '0;
      pre_data   = 8'd0;

      // Clear RAM and model while held in reset.
      for (int i = 0; i <= MASK; i++) begin
         @(negedge clk);
         pre_we     = 1'b1;
         pre_addr   = AW'(i);
         pre_data   = 8'd0;
         ref_mem[i] = 8'd0;
      end
      @(negedge clk);
      pre_we = 1'b0;
      check_reset_outputs("in_reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("after_reset");

      // cpu_halted outside RUN is ignored.
      pulse_halted();
      repeat (20) @(negedge clk);

      // Reset mid-LOAD after 2 of 4 data bytes.
      exp_wa.push_back(12'h040); exp_wd.push_back(8'hAA); ref_mem[12'h040] = 8'hAA;
      exp_wa.push_back(12'h041); exp_wd.push_back(8'hBB); ref_mem[12'h041] = 8'hBB;
      send_byte(8'h4C, 3); send_byte(8'h00, 3); send_byte(8'h40, 3); send_byte(8'h04, 3);
      send_byte(8'hAA, 3); send_byte(8'hBB, 3);
      wait_quiet("partial_load_done", 200);
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_load_reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      host_dump(12'h040, 2);
      wait_quiet("dump_after_reset_done", 500);
      check("dump_after_reset_b0", tx_log[tx_log.size()-2], 8'hAA);
      check("dump_after_reset_b1", tx_log[tx_log.size()-1], 8'hBB);

      // Plain 3-byte load.
      payload = '{8'hAA, 8'hBB, 8'hCC};
      host_load(12'h010, 3, 3);
      wait_quiet("load3_done", 500);
      check("ram_010", int'(ram[9'h010]), 8'hAA);
      check("ram_011", int'(ram[9'h011]), 8'hBB);
      check("ram_012", int'(ram[9'h012]), 8'hCC);
      check("load3_ack", tx_log[tx_log.size()-1], 8'h2E);

      // Wrapping load, data bytes on consecutive cycles (second lands in LOAD_WR).
      payload = '{8'h11, 8'h22};
      host_load(12'h1FF, 2, 0);
      wait_quiet("load_wrap_done", 500);
      check("ram_1ff", int'(ram[9'h1FF]), 8'h11);
      check("ram_000", int'(ram[9'h000]), 8'h22);

      // Dump preloaded bytes.
      @(negedge clk); pre_we = 1'b1; pre_addr = 9'h020; pre_data = 8'h5A;
      @(negedge clk); pre_addr = 9'h021; pre_data = 8'hA5;
      @(negedge clk); pre_we = 1'b0;
      ref_mem[12'h020] = 8'h5A;
      ref_mem[12'h021] = 8'hA5;
      host_dump(12'h020, 2);
      wait_quiet("dump2_done", 500);
      check("dump2_b0", tx_log[tx_log.size()-2], 8'h5A);
      check("dump2_b1", tx_log[tx_log.size()-1], 8'hA5);

      // Go, ignore bytes while running, then halt.
      exp_run.push_back(12'h123);
      send_byte(8'h47, 3); send_byte(8'h01, 3); send_byte(8'h23, 3);
      wait_quiet("go_run_done", 200);
      check("run_mem_sel", int'(mem_sel), 0);
      check("run_startaddr", int'(startaddr), 12'h123);
      send_byte(8'h55, 3);
      send_byte(8'h4C, 10);
      exp_tx.push_back(8'h21);
      pulse_halted();
      wait_quiet("halt_done", 200);
      check("halt_mem_sel", int'(mem_sel), 1);
      check("halt_tx", tx_log[tx_log.size()-1], 8'h21);

      // Reset during RUN; upper address bits dropped (0xFE80 -> 0x080).
      exp_run.push_back((16'hFE80) & MASK);
      send_byte(8'h47, 3); send_byte(8'hFE, 3); send_byte(8'h80, 3);
      wait_quiet("go2_run_done", 200);
      check("go2_startaddr", int'(startaddr), 12'h080);
      rst = 1'b0;
      #1;
      check("run_reset_mem_sel", int'(mem_sel), 1);
      check("run_reset_startaddr", int'(startaddr), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_halted();
      repeat (20) @(negedge clk);

      // Unknown command.
      exp_tx.push_back(8'h3F);
      send_byte(8'h55, 3);
      wait_quiet("bad_cmd_done", 200);
      check("bad_cmd_tx", tx_log[tx_log.size()-1], 8'h3F);

      // n=0 means 256 bytes.
      payload.delete();
      for (int i = 0; i < 256; i++) payload.push_back((i * 37 + 5) & 255);
      host_load(12'h000, 0, 1);
      wait_quiet("load256_done", 5000);
      check("ram_0ff", int'(ram[9'h0FF]), (255 * 37 + 5) & 255);
      check("ram_100_untouched", int'(ram[9'h100]), 0);

      // 256-byte dump wrapping from 0x1F0.
      host_dump(12'h1F0, 0);
      wait_quiet("dump256_done", 20000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial monitor and boot loader that sits upstream of the CPU.
- While the CPU is idle it owns the RAM ports and the UART. It executes host commands received over the UART: load bytes into RAM, dump RAM, and start the CPU at a given address.
- It starts the CPU with a one-cycle run pulse plus startaddr, then waits for the CPU's halted pulse and reports completion to the host.
- An external mux uses mem_sel to choose between loader and CPU RAM/UART signals.

Parameters:
addr_width, 9, RAM address width; must be 9..16.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
received  input  1  one-cycle strobe: rx_byte valid
rx_byte  input  8  received UART byte
is_transmitting  input  1  UART transmitter busy
tx_byte  output  8  byte to transmit
transmit  output  1  one-cycle transmit strobe
raddr  output  addr_width  RAM read address
waddr  output  addr_width  RAM write address
dwrite  output  8  RAM write data
write_en  output  1  one-cycle RAM write strobe
dread  input  8  RAM read data
mem_sel  output  1  1 = loader owns RAM/UART, 0 = CPU owns them
cpu_run  output  1  one-cycle start pulse, drives the CPU run input
startaddr  output  addr_width  CPU start address, held stable
cpu_halted  input  1  one-cycle pulse from the CPU on HLT

Behaviour:
Reset (rst low, async):
- state=IDLE, mem_sel=1.
- transmit, write_en and cpu_run are 0.
- tx_byte, raddr, waddr, dwrite, startaddr, count and address register are all 0.

Output strobes:
- transmit, write_en and cpu_run default to 0 every cycle; each is high for exactly one cycle when asserted.

Address assembly:
- addr <= {ah,al}[addr_width-1:0]; upper bits are silently dropped.
- addr increments modulo 2^addr_width, so 0x1FF+1 = 0x000 at width 9.
- Length byte n: 0 means 256.

Command byte handling in IDLE (one byte consumed per received strobe; no action without a strobe):
- 0x4C 'L': collect ah, al, n, then n data bytes. Each data byte is written the cycle after its strobe: waddr=addr, dwrite=byte, write_en=1, addr++. After the last byte, send ACK 0x2E.
- 0x44 'D': collect ah, al, n, then dump n bytes. Per byte: DUMP_RD (raddr<=addr), DUMP_WAIT, DUMP_LATCH (capture dread, addr++), then send the byte. Return to DUMP_RD until count reaches 0, then return to IDLE. No ACK is sent.
- 0x47 'G': collect ah, al, then GO:
  - startaddr<=addr, mem_sel<=0, cpu_run=1 for one cycle, then enter RUN.
  - In RUN all received strobes are ignored (the CPU owns the UART).
  - On cpu_halted: mem_sel<=1, send 0x21 '!', return to IDLE.
- Any other byte: send 0x3F '?' and return to IDLE.

Send sub-sequence (TX_WAIT):
- Hold until is_transmitting=0, then load tx_byte and pulse transmit.
- A one-cycle TX_GUARD follows so the UART busy flag can rise before it is sampled again.
- Bytes received during TX_WAIT/TX_GUARD are dropped.

States:
- IDLE, GET_AH, GET_AL, GET_N, LOAD_DATA, LOAD_WR, DUMP_RD, DUMP_WAIT, DUMP_LATCH, TX_WAIT, TX_GUARD, GO, RUN.
- A return-state register selects the destination after TX_GUARD: IDLE or DUMP_RD.

Boundary conditions:
- Load/dump wraps at the top of memory.
- received arriving in the same cycle as LOAD_WR: the write completes first, and the new byte is still captured. Received bytes are never lost in LOAD; the host sends at UART rate, far slower than one byte per 2 cycles.
- cpu_halted outside RUN is ignored.
- A reset during RUN returns the block to IDLE with mem_sel=1. startaddr is cleared.
- count is 9 bits so that n=256 is representable.

Test Plan:
- Reset mid-LOAD after 2 of 4 data bytes -> mem_sel=1, state IDLE, outputs 0; a following 'D' command works normally.
- Send 4C 00 10 03 AA BB CC -> writes 0x010=AA, 0x011=BB, 0x012=CC (3 write_en pulses), then tx 0x2E.
- Send 4C 01 FF 02 11 22 (addr_width=9) -> 0x1FF=11, 0x000=22 (wrap), then tx 0x2E.
- Preload RAM 0x020..0x021 = 5A,A5; send 44 00 20 02 -> tx 5A then A5, each transmit issued only while is_transmitting=0, dread sampled 2 cycles after raddr.
- Send 47 01 23 -> startaddr=0x123, cpu_run pulse one cycle, mem_sel=0. Bytes sent while RUN are ignored. Pulse cpu_halted -> mem_sel=1, tx 0x21.
- Send 0x55 -> tx 0x3F, back to IDLE; then 4C 00 00 00 followed by 256 bytes -> 256 writes, tx 0x2E.
